// File: rtl/brick_hit_arbiter.sv
// Serialises brick-hit events from several shell objects onto the single-cell
// hit port of the brick matrix, one collision pulse plus low gap per hit, round-robin.
module brick_hit_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int COLS         = 17,
  parameter int ROWS         = 14,
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 1
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic [NUM_REQ-1:0]      hitReq,
  input  logic [NUM_REQ-1:0][4:0] hitX,
  input  logic [NUM_REQ-1:0][3:0] hitY,
  output logic [4:0]              brickCollisionX,
  output logic [3:0]              brickCollisionY,
  output logic                    collision,
  output logic [NUM_REQ-1:0]      hitAck,
  output logic                    droppedHit,
  output logic                    busy
);

  localparam int CMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int GW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYCLES - 1);
  localparam logic [GW-1:0] LAST_REQ   = GW'(NUM_REQ - 1);
  // One extra bit so a limit of 32 columns / 16 rows still compares correctly
  localparam logic [5:0]    COLS_LIM   = 6'(COLS);
  localparam logic [4:0]    ROWS_LIM   = 5'(ROWS);

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  state_t              state_reg, state_next;
  logic [CW-1:0]       cnt_reg, cnt_next;
  logic [GW-1:0]       last_grant_reg, last_grant_next, grant_idx, idx;
  logic                grant_found;
  logic [NUM_REQ-1:0]  prev_req_reg, pending_reg, pending_next;
  logic [NUM_REQ-1:0]  rise, accept, drop, clear;
  logic [4:0]          lat_x_reg [NUM_REQ];
  logic [3:0]          lat_y_reg [NUM_REQ];
  logic [4:0]          x_next;
  logic [3:0]          y_next;
  logic                collision_next;
  logic                finish;

  assign rise   = hitReq & ~prev_req_reg;
  assign finish = (state_reg == PULSE) && (cnt_reg == '0);

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      logic in_range;
      assign in_range   = ({1'b0, hitX[gi]} < COLS_LIM) && ({1'b0, hitY[gi]} < ROWS_LIM);
      assign clear[gi]  = finish && (last_grant_reg == GW'(gi));
      // A new hit arriving on the very edge its predecessor completes is kept
      assign accept[gi] = rise[gi] && in_range && (!pending_reg[gi] || clear[gi]);
      assign drop[gi]   = rise[gi] && !in_range;

      always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
          lat_x_reg[gi] <= '0;
          lat_y_reg[gi] <= '0;
        end else if (accept[gi]) begin
          lat_x_reg[gi] <= hitX[gi];
          lat_y_reg[gi] <= hitY[gi];
        end
      end
    end
  endgenerate

  assign pending_next = (pending_reg & ~clear) | accept;
  assign busy         = (state_reg != IDLE) || (|pending_reg);

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = last_grant_reg;
    idx         = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = GW'((int'(last_grant_reg) + k) % NUM_REQ);
      if (!grant_found && pending_reg[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx;
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    last_grant_next = last_grant_reg;
    collision_next  = collision;
    x_next          = brickCollisionX;
    y_next          = brickCollisionY;
    case (state_reg)
      IDLE: begin
        if (grant_found) begin
          state_next      = PULSE;
          cnt_next        = PULSE_LOAD;
          last_grant_next = grant_idx;
          collision_next  = 1'b1;
          x_next          = lat_x_reg[grant_idx];
          y_next          = lat_y_reg[grant_idx];
        end
      end
      PULSE: begin
        if (cnt_reg == '0) begin
          state_next     = GAP;
          cnt_next       = GAP_LOAD;
          collision_next = 1'b0;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      GAP: begin
        if (cnt_reg == '0) state_next = IDLE;
        else               cnt_next   = cnt_reg - 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      last_grant_reg  <= LAST_REQ;
      prev_req_reg    <= '0;
      pending_reg     <= '0;
      collision       <= 1'b0;
      brickCollisionX <= '0;
      brickCollisionY <= '0;
      hitAck          <= '0;
      droppedHit      <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      last_grant_reg  <= last_grant_next;
      prev_req_reg    <= hitReq;
      pending_reg     <= pending_next;
      collision       <= collision_next;
      brickCollisionX <= x_next;
      brickCollisionY <= y_next;
      hitAck          <= clear | drop;
      droppedHit      <= |drop;
    end
  end

endmodule

// File: tb/tb_brick_hit_arbiter.sv
// Directed bench for brick_hit_arbiter: hand-computed cycle checks plus a
// collision-window monitor that logs each granted cell and checks pulse/gap lengths.
module tb_brick_hit_arbiter;

  logic            clk = 1'b0;
  logic            resetN = 1'b0;
  logic [3:0]      hit_req = '0;
  logic [3:0][4:0] hit_x = '0;
  logic [3:0][3:0] hit_y = '0;
  logic [4:0]      col_x;
  logic [3:0]      col_y;
  logic            collision;
  logic [3:0]      hit_ack;
  logic            dropped_hit;
  logic            busy;

  int              n_checks = 0;
  int              n_fail = 0;
  logic [8:0]      grants[$];
  logic            prev_col = 1'b0;
  int              hi_len = 0;
  int              lo_len = 99;

  brick_hit_arbiter dut (
    .clk(clk), .resetN(resetN), .hitReq(hit_req), .hitX(hit_x), .hitY(hit_y),
    .brickCollisionX(col_x), .brickCollisionY(col_y), .collision(collision),
    .hitAck(hit_ack), .droppedHit(dropped_hit), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("pass %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetN  = 1'b0;
    hit_req = '0;
    repeat (2) @(posedge clk);
    #3 resetN = 1'b1;
    tick();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  // Collision-window monitor: records each grant, checks high length and low gap
  initial begin
    forever begin
      @(negedge clk);
      if (!resetN) begin
        prev_col = 1'b0;
        hi_len   = 0;
        lo_len   = 99;
      end else begin
        if (collision) begin
          if (!prev_col) begin
            check("gap_ge_2", 32'(lo_len >= 2), 32'd1);
            grants.push_back({col_x, col_y});
            hi_len = 0;
          end
          hi_len++;
        end else begin
          if (prev_col) begin
            check("pulse_len", 32'(hi_len), 32'd2);
            lo_len = 0;
          end
          lo_len++;
        end
        prev_col = collision;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_collision", 32'(collision), 32'd0);
    check("rst_x", 32'(col_x), 32'd0);
    check("rst_y", 32'(col_y), 32'd0);
    check("rst_ack", 32'(hit_ack), 32'd0);
    check("rst_drop", 32'(dropped_hit), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #3 resetN = 1'b1;
    tick();

    // Single hit: rise at edge k, collision after k+1 and k+2, ack after k+3
    hit_x[0] = 5'd5; hit_y[0] = 4'd3; hit_req[0] = 1'b1;
    tick();
    check("s1_busy", 32'(busy), 32'd1);
    check("s1_col_k", 32'(collision), 32'd0);
    tick();
    check("s1_col_k1", 32'(collision), 32'd1);
    check("s1_x", 32'(col_x), 32'd5);
    check("s1_y", 32'(col_y), 32'd3);
    tick();
    check("s1_col_k2", 32'(collision), 32'd1);
    tick();
    check("s1_col_k3", 32'(collision), 32'd0);
    check("s1_ack_k3", 32'(hit_ack), 32'h1);
    check("s1_x_hold", 32'(col_x), 32'd5);
    tick();
    check("s1_ack_k4", 32'(hit_ack), 32'h0);
    check("s1_busy_k4", 32'(busy), 32'd0);
    hit_req[0] = 1'b0;
    tick();

    // Simultaneous hits on req1 and req3 with lastGrant=3
    do_reset();
    grants.delete();
    hit_x[1] = 5'd2; hit_y[1] = 4'd2; hit_x[3] = 5'd7; hit_y[3] = 4'd9;
    hit_req[1] = 1'b1; hit_req[3] = 1'b1;
    tick();
    tick();
    check("sim_col1", 32'(collision), 32'd1);
    check("sim_x1", 32'(col_x), 32'd2);
    check("sim_y1", 32'(col_y), 32'd2);
    tick();
    tick();
    check("sim_ack1", 32'(hit_ack), 32'h2);
    tick();
    check("sim_gap", 32'(collision), 32'd0);
    tick();
    check("sim_col2", 32'(collision), 32'd1);
    check("sim_x2", 32'(col_x), 32'd7);
    check("sim_y2", 32'(col_y), 32'd9);
    wait_idle("sim_idle");
    check("sim_count", 32'(grants.size()), 32'd2);
    if (grants.size() == 2) begin
      check("sim_first", 32'(grants[0]), 32'({5'd2, 4'd2}));
      check("sim_second", 32'(grants[1]), 32'({5'd7, 4'd9}));
    end
    hit_req = '0;
    tick();

    // Held-high request yields a single window
    grants.delete();
    hit_x[0] = 5'd4; hit_y[0] = 4'd4; hit_req[0] = 1'b1;
    repeat (50) tick();
    check("held_count", 32'(grants.size()), 32'd1);
    check("held_busy", 32'(busy), 32'd0);
    hit_req[0] = 1'b0;
    tick();

    // Second rise while still pending is ignored
    grants.delete();
    hit_x[0] = 5'd1; hit_y[0] = 4'd1; hit_req[0] = 1'b1;
    tick();
    hit_req[0] = 1'b0;
    tick();
    hit_x[0] = 5'd9; hit_req[0] = 1'b1;
    tick();
    hit_req[0] = 1'b0;
    wait_idle("ign_idle");
    check("ign_count", 32'(grants.size()), 32'd1);
    if (grants.size() > 0) check("ign_coord", 32'(grants[0]), 32'({5'd1, 4'd1}));

    // Rise on the completing edge is accepted with new coordinates
    grants.delete();
    hit_x[0] = 5'd1; hit_y[0] = 4'd1; hit_req[0] = 1'b1;
    tick();
    hit_req[0] = 1'b0;
    tick();
    tick();
    hit_x[0] = 5'd10; hit_y[0] = 4'd12; hit_req[0] = 1'b1;
    tick();
    check("ackedge_ack", 32'(hit_ack), 32'h1);
    wait_idle("ackedge_idle");
    check("ackedge_count", 32'(grants.size()), 32'd2);
    if (grants.size() == 2) check("ackedge_coord", 32'(grants[1]), 32'({5'd10, 4'd12}));
    hit_req = '0;
    tick();

    // Out-of-range hits are dropped; the last in-range cell is accepted
    grants.delete();
    hit_x[2] = 5'd17; hit_y[2] = 4'd0; hit_req[2] = 1'b1;
    tick();
    check("oor_x_ack", 32'(hit_ack), 32'h4);
    check("oor_x_drop", 32'(dropped_hit), 32'd1);
    check("oor_x_busy", 32'(busy), 32'd0);
    tick();
    check("oor_x_ack_clr", 32'(hit_ack), 32'h0);
    check("oor_x_drop_clr", 32'(dropped_hit), 32'd0);
    hit_req[2] = 1'b0;
    tick();
    hit_x[2] = 5'd0; hit_y[2] = 4'd14; hit_req[2] = 1'b1;
    tick();
    check("oor_y_ack", 32'(hit_ack), 32'h4);
    check("oor_y_drop", 32'(dropped_hit), 32'd1);
    hit_req[2] = 1'b0;
    repeat (4) tick();
    check("oor_no_col", 32'(grants.size()), 32'd0);
    hit_x[2] = 5'd16; hit_y[2] = 4'd13; hit_req[2] = 1'b1;
    tick();
    check("edge_in_drop", 32'(dropped_hit), 32'd0);
    wait_idle("edge_in_idle");
    check("edge_in_count", 32'(grants.size()), 32'd1);
    if (grants.size() > 0) check("edge_in_coord", 32'(grants[0]), 32'({5'd16, 4'd13}));
    hit_req = '0;
    tick();

    // Round-robin: req0 and req1 re-request right after each ack
    do_reset();
    grants.delete();
    hit_x[0] = 5'd3; hit_y[0] = 4'd0; hit_x[1] = 5'd6; hit_y[1] = 4'd1;
    hit_req[0] = 1'b1; hit_req[1] = 1'b1;
    begin
      int n = 0;
      while (grants.size() < 20 && n < 400) begin
        tick();
        n++;
        for (int i = 0; i < 2; i++) begin
          if (hit_ack[i]) hit_req[i] = 1'b0;
          else if (!hit_req[i]) hit_req[i] = 1'b1;
        end
      end
    end
    check("rr_count", 32'(grants.size()), 32'd20);
    for (int k = 0; k < grants.size(); k++) begin
      check($sformatf("rr_grant%0d", k), 32'(grants[k][8:4]), (k % 2 == 0) ? 32'd3 : 32'd6);
    end
    hit_req = '0;
    wait_idle("rr_idle");

    // Asynchronous reset while a pulse is active with three hits pending
    do_reset();
    hit_x[0] = 5'd1; hit_x[1] = 5'd2; hit_x[2] = 5'd3;
    hit_y[0] = 4'd0; hit_y[1] = 4'd0; hit_y[2] = 4'd0;
    hit_req = 4'b0111;
    tick();
    tick();
    check("mid_col_before", 32'(collision), 32'd1);
    #2 resetN = 1'b0;
    #1;
    check("mid_col_async", 32'(collision), 32'd0);
    check("mid_busy_async", 32'(busy), 32'd0);
    hit_req = '0;
    @(posedge clk);
    #3 resetN = 1'b1;
    grants.delete();
    repeat (10) tick();
    check("mid_no_col", 32'(grants.size()), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    hit_x[1] = 5'd8; hit_y[1] = 4'd5; hit_req[1] = 1'b1;
    tick();
    tick();
    check("mid_new_col", 32'(collision), 32'd1);
    check("mid_new_x", 32'(col_x), 32'd8);
    wait_idle("mid_idle");
    hit_req = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
